// File: rtl/uart_pkg.sv
// Shared constants, state type and divisor helper for the UART receive path.
package uart_pkg;

  localparam int unsigned DIV_4800   = 1302;
  localparam int unsigned DIV_9600   = 651;
  localparam int unsigned DIV_115200 = 54;
  localparam int unsigned DIV_1BAUD  = 6_250_000;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned DIV_W      = 23;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  // Reload value (divisor - 1) for a baud code; a nonzero sim_div overrides all codes.
  function automatic logic [DIV_W-1:0] div_reload(input logic [1:0] sel,
                                                   input int unsigned sim_div);
    int unsigned divisor;
    if (sim_div != 0) begin
      divisor = sim_div;
    end else begin
      case (sel)
        2'b00:   divisor = DIV_4800;
        2'b01:   divisor = DIV_9600;
        2'b10:   divisor = DIV_115200;
        default: divisor = DIV_1BAUD;
      endcase
    end
    return DIV_W'(divisor - 1);
  endfunction

endpackage

// File: rtl/baud_tick_gen_rx.sv
// 16x oversample tick generator; restart re-phases the divider to a start edge.
module baud_tick_gen_rx
  import uart_pkg::*;
#(
  parameter int unsigned SIM_DIV = 0
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       restart,
  output logic       tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] reload;

  // Reload value for the currently selected divisor.
  always_comb begin
    reload = div_reload(sel, SIM_DIV);
  end

  // Down-count, reloading at zero or when a new frame re-phases the divider.
  always_comb begin
    cnt_d = cnt_q - DIV_W'(1);
    if (restart || (cnt_q == '0)) begin
      cnt_d = reload;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_receiver_rx.sv
// UART receive path: synchronizer, baud latch, framing FSM, shift register, outputs.
module uart_receiver_rx
  import uart_pkg::*;
#(
  parameter int unsigned SIM_DIV = 0
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [1:0] S,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       framing_error,
  output logic       busy
);

  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [1:0]           s_lat_q;
  rx_state_t            state_q;
  logic [3:0]           tick_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 rx_valid_q;
  logic                 framing_error_q;
  logic                 busy_q;

  logic                 start_det;
  logic [1:0]           div_sel;
  logic                 tick;

  // Start edge seen while idle; the divider must use the code being latched now.
  always_comb begin
    start_det = (state_q == IDLE) && !rx_s_q;
    div_sel   = start_det ? S : s_lat_q;
  end

  baud_tick_gen_rx #(
    .SIM_DIV(SIM_DIV)
  ) u_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .sel    (div_sel),
    .restart(start_det),
    .tick   (tick)
  );

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Framing FSM with shift register and registered output strobes.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q         <= IDLE;
      s_lat_q         <= 2'b11;
      tick_cnt_q      <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      data_out_q      <= '0;
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            s_lat_q    <= S;
            tick_cnt_q <= '0;
            state_q    <= START;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt_q == 4'(OVERSAMPLE / 2 - 1)) begin
              if (!rx_s_q) begin
                state_q    <= DATA;
                bit_idx_q  <= '0;
                tick_cnt_q <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                state_q <= STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
              tick_cnt_q <= '0;
              if (rx_s_q) begin
                data_out_q <= shift_q;
                rx_valid_q <= 1'b1;
                state_q    <= IDLE;
                busy_q     <= 1'b0;
              end else begin
                framing_error_q <= 1'b1;
                state_q         <= BREAK;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        BREAK: begin
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out      = data_out_q;
  assign rx_valid      = rx_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_receiver_rx.sv
// Bench for uart_receiver_rx: sample-point reference model plus directed and random frames.
module tb_uart_receiver_rx;

  localparam int unsigned D   = 4;
  localparam int          BIT = 64;

  logic       clk;
  logic       reset;
  logic [1:0] S;
  logic       rx_in;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       framing_error;
  logic       busy;

  uart_receiver_rx #(.SIM_DIV(D)) dut (
    .clk_in       (clk),
    .reset        (reset),
    .S            (S),
    .rx_in        (rx_in),
    .data_out     (data_out),
    .rx_valid     (rx_valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: line history and the sample-point schedule measured from detection.
  int       mode = 0;       // 0 idle, 1 in frame, 2 waiting for line high
  int       det_cyc = 0;
  bit       m1 = 1'b1, m2 = 1'b1, s_now;
  bit [7:0] bits = '0;
  bit [7:0] e_data = '0;
  bit       e_valid = 1'b0, e_fe = 1'b0, e_busy = 1'b0;

  always @(posedge clk) begin
    int rel;
    cyc++;
    if (!reset) begin
      m1 = 1'b1; m2 = 1'b1; mode = 0;
      e_data = '0; e_valid = 1'b0; e_fe = 1'b0;
    end else begin
      s_now = m2; m2 = m1; m1 = rx_in;
      e_valid = 1'b0; e_fe = 1'b0;
      case (mode)
        0: if (!s_now) begin mode = 1; det_cyc = cyc; end
        1: begin
          rel = cyc - det_cyc;
          if (rel == 8 * D) begin
            if (s_now) mode = 0;
          end else if (rel > 8 * D && rel < 152 * D && ((rel - 8 * D) % (16 * D)) == 0) begin
            bits[(rel - 8 * D) / (16 * D) - 1] = s_now;
          end else if (rel == 152 * D) begin
            if (s_now) begin e_data = bits; e_valid = 1'b1; mode = 0; end
            else begin e_fe = 1'b1; mode = 2; end
          end
        end
        default: if (s_now) mode = 0;
      endcase
    end
    e_busy = (mode != 0);
  end

  // Observed pulse bookkeeping and per-cycle comparison against the model.
  int       n_valid = 0, n_fe = 0, busy_cnt = 0, last_valid_cyc = 0;
  bit [7:0] vq[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_out", 32'(data_out), 32'(e_data));
      chk("rx_valid", 32'(rx_valid), 32'(e_valid));
      chk("framing_error", 32'(framing_error), 32'(e_fe));
      chk("busy", 32'(busy), 32'(e_busy));
      if (rx_valid === 1'b1) begin
        n_valid++; vq.push_back(data_out); last_valid_cyc = cyc;
      end
      if (framing_error === 1'b1) n_fe++;
      if (busy === 1'b1) busy_cnt++;
    end
  end

  task automatic hold(input logic v, input int n);
    rx_in = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drive one frame; abort_at >= 0 pulses reset at that cycle and releases the line.
  task automatic send(input logic [7:0] b, input logic stop, input int abort_at);
    for (int i = 0; i < 10 * BIT; i++) begin
      int j;
      j = i / BIT;
      if (i == abort_at) begin
        reset = 1'b0; rx_in = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      rx_in = (j == 0) ? 1'b0 : (j <= 8) ? b[j-1] : stop;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int t0, nv0, nf0, q0, good;
    logic [7:0] rb;
    logic rs;
    reset = 1'b0; S = 2'b10; rx_in = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("reset_data_out", 32'(data_out), 32'h00);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_framing_error", 32'(framing_error), 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    hold(1'b1, 20);

    // Basic frame
    nv0 = n_valid; nf0 = n_fe; t0 = cyc;
    send(8'hA5, 1'b1, -1);
    hold(1'b1, 50);
    chk("basic_count", 32'(n_valid - nv0), 32'd1);
    chk("basic_data", 32'(data_out), 32'hA5);
    chk("basic_latency", 32'(last_valid_cyc - t0), 32'd611);
    chk("basic_no_fe", 32'(n_fe - nf0), 32'd0);

    // Glitch rejection
    nv0 = n_valid; busy_cnt = 0;
    hold(1'b0, 10);
    hold(1'b1, 100);
    chk("glitch_busy_window", 32'(busy_cnt >= 30 && busy_cnt <= 34), 32'd1);
    chk("glitch_no_valid", 32'(n_valid - nv0), 32'd0);

    // Framing error with held-low line
    nv0 = n_valid; nf0 = n_fe;
    send(8'h3C, 1'b0, -1);
    hold(1'b0, 200);
    chk("break_busy", 32'(busy), 32'd1);
    hold(1'b1, 50);
    chk("fe_count", 32'(n_fe - nf0), 32'd1);
    chk("fe_no_valid", 32'(n_valid - nv0), 32'd0);
    chk("fe_data_kept", 32'(data_out), 32'hA5);
    chk("fe_busy_after", 32'(busy), 32'd0);

    // Back-to-back
    q0 = vq.size();
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    hold(1'b1, 50);
    chk("b2b_count", 32'(vq.size() - q0), 32'd2);
    if (vq.size() >= q0 + 2) begin
      chk("b2b_first", 32'(vq[q0]), 32'h00);
      chk("b2b_second", 32'(vq[q0+1]), 32'hFF);
    end

    // S change mid-frame
    q0 = vq.size();
    fork
      send(8'h96, 1'b1, -1);
      begin repeat (300) @(posedge clk); #1; S = 2'b00; end
    join
    hold(1'b1, 20);
    send(8'h69, 1'b1, -1);
    hold(1'b1, 50);
    chk("schg_count", 32'(vq.size() - q0), 32'd2);
    if (vq.size() >= q0 + 2) begin
      chk("schg_first", 32'(vq[q0]), 32'h96);
      chk("schg_second", 32'(vq[q0+1]), 32'h69);
    end
    S = 2'b10;

    // Reset during bit 4
    nv0 = n_valid; nf0 = n_fe;
    send(8'hC3, 1'b1, 5 * BIT + 32);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    hold(1'b1, 700);
    chk("rst_no_pulse", 32'((n_valid - nv0) + (n_fe - nf0)), 32'd0);
    send(8'h5A, 1'b1, -1);
    hold(1'b1, 50);
    chk("rst_next_data", 32'(data_out), 32'h5A);
    chk("rst_next_count", 32'(n_valid - nv0), 32'd1);

    // Random frames, glitches, bad stops and gaps
    nv0 = n_valid; good = 0;
    for (int k = 0; k < 24; k++) begin
      int r;
      r = $urandom_range(0, 9);
      S = 2'($urandom_range(0, 3));
      if (r == 0) begin
        hold(1'b0, $urandom_range(1, 20));
        hold(1'b1, 60);
      end else begin
        rb = 8'($urandom);
        rs = (r != 1);
        send(rb, rs, -1);
        if (rs) begin
          good++;
          hold(1'b1, $urandom_range(0, 40));
        end else begin
          hold(1'b0, $urandom_range(0, 100));
          hold(1'b1, $urandom_range(1, 40));
        end
      end
    end
    hold(1'b1, 100);
    chk("rand_valid_count", 32'(n_valid - nv0), 32'(good));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver_rx.md
# uart_receiver_rx

Serial receive path of the UART controller, mirroring the transmit side's baud-rate selection. Samples the asynchronous `rx_in` line at 16× the selected baud rate, detects and validates a start bit, shifts in 8 data bits LSB-first, checks the stop bit, and presents each received byte with a one-cycle valid strobe. It sits between the board RX pin and the controller's receive logic, and uses the same 2-bit `S` baud code as the transmitter.

## Interface
- `SIM_DIV`, default 0: if nonzero, replaces every oversample divisor (simulation only).
- `clk_in`  input  1  system clock, 100 MHz.
- `reset`  input  1  synchronous reset, active-low.
- `S`  input  2  baud select: 00=4800, 01=9600, 10=115200, 11=1 baud.
- `rx_in`  input  1  asynchronous serial line, idle high.
- `data_out`  output  8  last correctly framed byte.
- `rx_valid`  output  1  one-cycle pulse when `data_out` updates.
- `framing_error`  output  1  one-cycle pulse on a bad stop bit.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer**
  - `rx_in` passes through 2 flops; reset value of both is 1.
  - All decisions use the synchronized value `rx_s`.
- **Divisor selection**
  - `S` is latched into `s_lat` only on the IDLE→START transition.
  - Changes to `S` mid-frame are ignored until the next frame.
- **Tick generator**
  - Down-counter reloads with `DIV[s_lat]-1` and emits `tick` for one cycle at zero.
  - The counter is forced to reload on start detection, so ticks are phase-aligned to the falling edge.
- **FSM states**
  - **IDLE:** `busy`=0. On `rx_s`=0, latch `S`, clear `tick_cnt`, restart the divider, and go to START.
  - **START:** after 8 ticks (bit midpoint):
    - `rx_s`=0 → DATA, with `bit_idx`=0 and `tick_cnt`=0.
    - `rx_s`=1 → IDLE (glitch rejected, no outputs).
  - **DATA:** every 16 ticks, sample `rx_s` into the shift register MSB position and shift right. After the sample with `bit_idx`=7, go to STOP.
  - **STOP:** after 16 ticks, sample `rx_s`:
    - 1 → `data_out`<=shift register, pulse `rx_valid`, go to IDLE.
    - 0 → pulse `framing_error`, leave `data_out` unchanged, go to BREAK.
  - **BREAK:** wait until `rx_s`=1, then go to IDLE. A held-low line never retriggers a start.
- **Widths:** divider counter 23 bits (max reload 6_249_999); `tick_cnt` 4 bits; `bit_idx` 3 bits.

## Timing
- **Reset values** (reset low at a `clk_in` edge):
  - `data_out`=8'h00, `rx_valid`=0, `framing_error`=0, `busy`=0.
  - FSM=IDLE, synchronizer=1, `s_lat`=2'b11, all counters 0.
- **Reset mid-frame:** the frame is abandoned, no pulse is emitted, and the block is in IDLE on the next cycle.
- **Start detection:** 2 cycles of synchronizer latency from the `rx_in` falling edge; `busy` rises 1 cycle after `rx_s` falls.
- **Sample points:** start-bit check at 8·D cycles after detection, where D = divisor. Data bit n is sampled at (8+16(n+1))·D; the stop bit at (8+16·9)·D = 152·D.
- **Completion:** `rx_valid` / `framing_error` is registered in the cycle following the stop-bit sample tick and lasts exactly 1 cycle. `busy` falls in the same cycle.
- **Back-to-back frames:** a start bit arriving in the cycle after IDLE re-entry is accepted.
- **Stop-bit margin:** the stop-bit sample occurs at the stop-bit midpoint. The next start edge may begin as early as half a bit later without loss.

## Structure
- **Package `uart_pkg`:**
  - localparams `DIV_4800`=1302, `DIV_9600`=651, `DIV_115200`=54, `DIV_1BAUD`=6_250_000.
  - `OVERSAMPLE`=16, `DATA_BITS`=8.
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t`.
- **Sub-module `baud_tick_gen_rx`:** inputs `clk_in`, `reset`, `sel`, `restart`; output `tick`.
- **Top-level:** synchronizer, `s_lat`, FSM, shift register, and output registers.

## Test plan
All scenarios use `SIM_DIV`=4, so one bit = 64 clocks, and `S`=10.
- **Basic frame:** send 0xA5 with a good stop bit → `data_out`=8'hA5 with a single `rx_valid` pulse about 152·4+3 cycles after the falling edge; `framing_error` stays 0.
- **Glitch rejection:** pulse `rx_in` low for 10 clocks → FSM returns to IDLE, no `rx_valid`, `busy` high for ≤ 34 cycles.
- **Framing error:** send 0x3C with a low stop bit, then hold the line low 200 clocks → one `framing_error` pulse, `data_out` keeps its previous value, `busy`=1 until the line goes high, and no new frame is reported.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two `rx_valid` pulses with values 8'h00 then 8'hFF.
- **S change mid-frame:** change `S` from 10 to 00 mid-frame → the byte is still received correctly; the next frame uses the new divisor.
- **Reset mid-frame:** assert `reset`=0 for 1 cycle during bit 4 → all outputs at reset values, no pulse, and a following frame (0x5A) is received correctly.
